pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_stage_skid.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register carrying {pc, instr} with a valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the outputs and the skid entry absorbs one extra word, so in_ready_o is a pure register output.
module pipe_stage_skid #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [PC_W-1:0]    pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o,
   input  logic               flush_i,
   input  logic               mem_stall_i,
   output logic [CNT_W-1:0]   stall_cnt_o,
   output logic [CNT_W-1:0]   flush_cnt_o
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t               state_p0, state_nxt;
   logic [PC_W-1:0]      main_pc_p0, skid_pc_p1;
   logic [INSTR_W-1:0]   main_instr_p0, skid_instr_p1;
   logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;
   logic                 vld_p0, vld_p1;
   logic                 accept, deliver;
   logic                 load_main_in, load_main_skid, load_skid_in;
   logic                 stall_hit, flush_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign vld_p0  = (state_p0 != EMPTY);
   assign vld_p1  = (state_p0 == FULL);
   assign accept  = ~mem_stall_i & in_valid_i & in_ready_o;
   assign deliver = ~mem_stall_i & vld_p0 & out_ready_i;

   // flush counts only when it actually throws away a held or incoming word
   assign flush_hit = ~mem_stall_i & flush_i & (vld_p0 | accept);
   assign stall_hit = vld_p0 & ~out_ready_i & ~mem_stall_i & ~flush_i;

   always_comb begin
      state_nxt      = state_p0;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (!mem_stall_i) begin
         if (flush_i) begin
            state_nxt = EMPTY;
         end else begin
            case (state_p0)
               EMPTY: if (accept) begin
                  state_nxt    = ONE;
                  load_main_in = 1'b1;
               end
               ONE: if (accept && deliver) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_nxt    = FULL;
                  load_skid_in = 1'b1;
               end else if (deliver) begin
                  state_nxt = EMPTY;
               end
               FULL: if (deliver) begin
                  state_nxt      = ONE;
                  load_main_skid = 1'b1;
               end
               default: state_nxt = EMPTY;
            endcase
         end
      end
   end

   // stage p0: control state and counters
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_p0    <= EMPTY;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_p0 <= state_nxt;
         if (stall_hit) stall_cnt_q <= sat_inc(stall_cnt_q);
         if (flush_hit) flush_cnt_q <= sat_inc(flush_cnt_q);
      end
   end

   // stage p0/p1: data entries, qualified by the state valids so they need no reset
   always_ff @(posedge clk_i) begin
      if (load_main_in) begin
         main_pc_p0    <= pc_i;
         main_instr_p0 <= instr_i;
      end else if (load_main_skid) begin
         main_pc_p0    <= skid_pc_p1;
         main_instr_p0 <= skid_instr_p1;
      end
      if (load_skid_in) begin
         skid_pc_p1    <= pc_i;
         skid_instr_p1 <= instr_i;
      end
   end

   assign in_ready_o  = ~vld_p1;
   assign out_valid_o = vld_p0;
   assign pc_o        = vld_p0 ? main_pc_p0 : '0;
   assign instr_o     = vld_p0 ? main_instr_p0 : NOP_INSTR;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenario tasks plus a randomized run checked against a queue model.
// Built with CNT_W=4 so counter saturation is reachable.
module tb_pipe_stage_skid;

   localparam int          PC_W  = 32;
   localparam int          IW    = 32;
   localparam int          CNT_W = 4;
   localparam int          CMAX  = 15;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, mem_stall = 1'b0;
   logic [PC_W-1:0] pc_in = '0;
   logic [IW-1:0]   instr_in = '0;
   logic            in_ready, out_valid;
   logic [PC_W-1:0] pc_out;
   logic [IW-1:0]   instr_out;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {logic [31:0] pc; logic [31:0] instr;} word_t;
   word_t q[$];
   int    m_stall = 0;
   int    m_flush = 0;

   pipe_stage_skid #(.PC_W(PC_W), .INSTR_W(IW), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .pc_i(pc_in), .instr_i(instr_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out), .instr_o(instr_out),
      .flush_i(flush), .mem_stall_i(mem_stall),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   // Behavioural model: a FIFO of at most two words, advanced once per rising edge.
   task automatic model_edge();
      bit acc, del;
      word_t w;
      if (!rst_n || mem_stall) return;
      acc = in_valid && (q.size() < 2);
      del = (q.size() > 0) && out_ready;
      if (flush) begin
         if ((q.size() > 0 || acc) && m_flush < CMAX) m_flush++;
         q.delete();
      end else begin
         if (q.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
         if (del) void'(q.pop_front());
         if (acc) begin
            w.pc = pc_in; w.instr = instr_in;
            q.push_back(w);
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                        input logic fl, input logic ms);
      in_valid = v; pc_in = pc; instr_in = ins_of(pc);
      out_ready = ordy; flush = fl; mem_stall = ms;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      q.delete(); m_stall = 0; m_flush = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== '0 || instr_out !== NOP)
         begin n_fail++; $display("FAIL reset_idle: vld=%b rdy=%b pc=%h ins=%h want 0 1 0 %h", out_valid, in_ready, pc_out, instr_out, NOP); end
      drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b0); step();
      n_checks++; if (in_ready !== 1'b0 || stall_cnt !== 4'd1)
         begin n_fail++; $display("FAIL reset_prefull: rdy=%b stall=%0d want 0 1", in_ready, stall_cnt); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pc_out !== '0 || instr_out !== NOP || stall_cnt !== '0 || flush_cnt !== '0)
         begin n_fail++; $display("FAIL reset_async: vld=%b rdy=%b pc=%h ins=%h st=%0d fl=%0d", out_valid, in_ready, pc_out, instr_out, stall_cnt, flush_cnt); end
      do_reset();
   endtask

   task automatic test_streaming();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 32'h100 + 4*k, 1'b1, 1'b0, 1'b0);
         step();
         n_checks++; if (out_valid !== 1'b1 || pc_out !== 32'h100 + 4*k || instr_out !== ins_of(32'h100 + 4*k) || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL stream_%0d: vld=%b pc=%h rdy=%b want 1 %h 1", k, out_valid, pc_out, in_ready, 32'h100 + 4*k); end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
      n_checks++; if (out_valid !== 1'b0 || stall_cnt !== '0)
         begin n_fail++; $display("FAIL stream_drain: vld=%b stall=%0d want 0 0", out_valid, stall_cnt); end
   endtask

   task automatic test_back_pressure();
      do_reset();
      drive(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0); step();
      n_checks++; if (pc_out !== 32'hA0 || in_ready !== 1'b1 || stall_cnt !== 4'd0)
         begin n_fail++; $display("FAIL bp_a: pc=%h rdy=%b st=%0d want a0 1 0", pc_out, in_ready, stall_cnt); end
      drive(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0); step();
      n_checks++; if (pc_out !== 32'hA0 || in_ready !== 1'b0 || stall_cnt !== 4'd1)
         begin n_fail++; $display("FAIL bp_b: pc=%h rdy=%b st=%0d want a0 0 1", pc_out, in_ready, stall_cnt); end
      drive(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0); step();
      n_checks++; if (pc_out !== 32'hA0 || in_ready !== 1'b0 || stall_cnt !== 4'd2)
         begin n_fail++; $display("FAIL bp_c_blocked: pc=%h rdy=%b st=%0d want a0 0 2", pc_out, in_ready, stall_cnt); end
      drive(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0); step();
      n_checks++; if (pc_out !== 32'hB0 || instr_out !== ins_of(32'hB0) || in_ready !== 1'b1 || stall_cnt !== 4'd2)
         begin n_fail++; $display("FAIL bp_rel_b: pc=%h rdy=%b st=%0d want b0 1 2", pc_out, in_ready, stall_cnt); end
      step();
      n_checks++; if (pc_out !== 32'hC0 || out_valid !== 1'b1)
         begin n_fail++; $display("FAIL bp_rel_c: pc=%h vld=%b want c0 1", pc_out, out_valid); end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); step();
      n_checks++; if (out_valid !== 1'b0 || pc_out !== '0 || instr_out !== NOP)
         begin n_fail++; $display("FAIL bp_empty: vld=%b pc=%h ins=%h want 0 0 %h", out_valid, pc_out, instr_out, NOP); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h208, 1'b0, 1'b1, 1'b0); step();
      n_checks++; if (out_valid !== 1'b0 || pc_out !== '0 || instr_out !== NOP || in_ready !== 1'b1 || flush_cnt !== 4'd1)
         begin n_fail++; $display("FAIL flush_full: vld=%b pc=%h ins=%h rdy=%b fc=%0d want 0 0 nop 1 1", out_valid, pc_out, instr_out, in_ready, flush_cnt); end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0); step();
      n_checks++; if (flush_cnt !== 4'd1 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL flush_empty: fc=%0d vld=%b want 1 0", flush_cnt, out_valid); end
      drive(1'b1, 32'h20C, 1'b0, 1'b1, 1'b0); step();
      n_checks++; if (flush_cnt !== 4'd2 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL flush_incoming: fc=%0d vld=%b want 2 0", flush_cnt, out_valid); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 32'h308, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (out_valid !== 1'b1 || pc_out !== 32'h300 || in_ready !== 1'b0 || stall_cnt !== 4'd1 || flush_cnt !== 4'd0)
            begin n_fail++; $display("FAIL memstall_%0d: vld=%b pc=%h rdy=%b st=%0d fc=%0d want 1 300 0 1 0", i, out_valid, pc_out, in_ready, stall_cnt, flush_cnt); end
      end
      mem_stall = 1'b0; step();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || flush_cnt !== 4'd1 || stall_cnt !== 4'd1)
         begin n_fail++; $display("FAIL memstall_release: vld=%b rdy=%b fc=%0d st=%0d want 0 1 1 1", out_valid, in_ready, flush_cnt, stall_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0); step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int j = 1; j <= (1 << CNT_W) + 5; j++) begin
         step();
         n_checks++; if (stall_cnt !== ((j > CMAX) ? CMAX : j))
            begin n_fail++; $display("FAIL sat_%0d: stall=%0d want %0d", j, stall_cnt, (j > CMAX) ? CMAX : j); end
      end
   endtask

   task automatic test_random();
      logic [31:0] epc, eins;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
         step();
         epc  = (q.size() > 0) ? q[0].pc : 32'h0;
         eins = (q.size() > 0) ? q[0].instr : NOP;
         n_checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || pc_out !== epc || instr_out !== eins
                         || stall_cnt !== m_stall[CNT_W-1:0] || flush_cnt !== m_flush[CNT_W-1:0])
            begin n_fail++; $display("FAIL rand_%0d: vld=%b rdy=%b pc=%h ins=%h st=%0d fc=%0d want %b %b %h %h %0d %0d", c, out_valid, in_ready, pc_out, instr_out, stall_cnt, flush_cnt, q.size() > 0, q.size() < 2, epc, eins, m_stall, m_flush); end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_mem_stall();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
